// File: rtl/maxpool_32_2_16_pkg.sv
// Shared types and helpers for the pooling stage.
// Data width, signed max and output-count arithmetic.
package nn_pkg;

  localparam int T = 16;

  typedef logic signed [T-1:0] data_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic data_t smax(data_t a, data_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/maxpool_32_2_16_pool_out_reg.sv
// Output holding register for the pooling stage.
// Loads a window result, holds it under backpressure.
module pool_out_reg
  import nn_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [T-1:0] data,
  input  logic         last,
  input  logic         m_ready_y,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  output logic         m_last_y,
  output logic         busy
);

  out_state_t state, state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  // A load in the same cycle as a consume keeps the register full.
  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (load) state_n = FULL;
      FULL:  if (m_ready_y && !load) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data_out_y <= '0;
      m_last_y     <= 1'b0;
    end else if (load) begin
      m_data_out_y <= data;
      m_last_y     <= last;
    end
  end

  assign m_valid_y = (state == FULL);
  assign busy      = m_valid_y & ~m_ready_y;

endmodule

// File: rtl/maxpool_32_2_16.sv
// 1-D max pooling over non-overlapping windows.
// Windows never cross a frame boundary.
module maxpool_32_2_16
  import nn_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter int POOL      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y,
  output logic         m_last_y
);

  localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [WW-1:0] win_cnt;
  logic [IW-1:0] in_cnt;
  data_t         cur_max;
  data_t         win_val;
  logic          frame_end;
  logic          closing;
  logic          acc;
  logic          busy;

  assign frame_end = (in_cnt == IW'(FRAME_LEN - 1));
  assign closing   = (win_cnt == WW'(POOL - 1)) | frame_end;

  // Only a closing sample needs the output register free.
  assign s_ready_x = ~reset & ~(closing & busy);
  assign acc       = s_valid_x & s_ready_x;

  assign win_val = (win_cnt == '0) ? data_t'(s_data_in_x)
                                   : smax(cur_max, data_t'(s_data_in_x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      in_cnt  <= '0;
      cur_max <= '0;
    end else if (acc) begin
      cur_max <= win_val;
      in_cnt  <= frame_end ? '0 : in_cnt + 1'b1;
      win_cnt <= closing ? '0 : win_cnt + 1'b1;
    end
  end

  pool_out_reg u_out (
    .clk          (clk),
    .reset        (reset),
    .load         (acc & closing),
    .data         (win_val),
    .last         (frame_end),
    .m_ready_y    (m_ready_y),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_last_y     (m_last_y),
    .busy         (busy)
  );

endmodule
